// File: rtl/mdu_pkg.sv
// Shared MDU encodings and defaults.
// The controller includes this too, for decoding mult/div/mfhi/mflo/mthi/mtlo.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Width of a down-counter that can hold the longer of the two latencies.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: multi-cycle mult/div with architectural HI/LO,
// mthi/mtlo writes, combinational mfhi/mflo read and a busy flag for the hazard unit.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [2:0]  MDUOp,
  input  logic        HILOSel,
  output logic        busy,
  output logic [31:0] HILOOut
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  hilo_t            hilo_reg, hilo_next;
  hilo_t            res_reg, res_next;
  logic             wr_en_reg, wr_en_next;

  mdu_op_e op;
  assign op = mdu_op_e'(MDUOp);

  // Arithmetic datapath, evaluated on the current operands every cycle.
  logic signed [63:0] sa64, sb64, prod_s;
  logic        [63:0] prod_u;
  logic               div_zero, div_ovf;
  logic signed [31:0] sdivisor, quot_s, rem_s;
  logic        [31:0] udivisor, quot_u, rem_u;
  hilo_t              mult_res, multu_res, div_res, divu_res;

  assign sa64   = $signed({{32{srcA[31]}}, srcA});
  assign sb64   = $signed({{32{srcB[31]}}, srcB});
  assign prod_s = sa64 * sb64;
  assign prod_u = {32'b0, srcA} * {32'b0, srcB};

  // Dividing by 1 instead yields exactly the required 0x80000000/-1 result,
  // and keeps the divide-by-zero case defined (its result is never written).
  assign div_zero = (srcB == 32'd0);
  assign div_ovf  = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
  assign sdivisor = (div_zero || div_ovf) ? 32'sd1 : $signed(srcB);
  assign udivisor = div_zero ? 32'd1 : srcB;

  assign quot_s = $signed(srcA) / sdivisor;
  assign rem_s  = $signed(srcA) % sdivisor;
  assign quot_u = srcA / udivisor;
  assign rem_u  = srcA % udivisor;

  assign mult_res  = '{hi: prod_s[63:32], lo: prod_s[31:0]};
  assign multu_res = '{hi: prod_u[63:32], lo: prod_u[31:0]};
  assign div_res   = '{hi: rem_s, lo: quot_s};
  assign divu_res  = '{hi: rem_u, lo: quot_u};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hilo_next  = hilo_reg;
    res_next   = res_reg;
    wr_en_next = wr_en_reg;

    case (state_reg)
      MDU_IDLE: begin
        case (op)
          MDU_MULT: begin
            res_next   = mult_res;
            wr_en_next = 1'b1;
            cnt_next   = MULT_LOAD;
            state_next = MDU_BUSY;
          end
          MDU_MULTU: begin
            res_next   = multu_res;
            wr_en_next = 1'b1;
            cnt_next   = MULT_LOAD;
            state_next = MDU_BUSY;
          end
          MDU_DIV: begin
            res_next   = div_res;
            wr_en_next = !div_zero;
            cnt_next   = DIV_LOAD;
            state_next = MDU_BUSY;
          end
          MDU_DIVU: begin
            res_next   = divu_res;
            wr_en_next = !div_zero;
            cnt_next   = DIV_LOAD;
            state_next = MDU_BUSY;
          end
          MDU_MTHI: hilo_next.hi = srcA;
          MDU_MTLO: hilo_next.lo = srcA;
          default: ;
        endcase
      end
      MDU_BUSY: begin
        // Opcodes are ignored here; only the countdown advances.
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = MDU_IDLE;
          if (wr_en_reg) begin
            hilo_next = res_reg;
          end
        end
      end
      default: state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= MDU_IDLE;
      cnt_reg   <= '0;
      hilo_reg  <= '0;
      res_reg   <= '0;
      wr_en_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hilo_reg  <= hilo_next;
      res_reg   <= res_next;
      wr_en_reg <= wr_en_next;
    end
  end

  assign busy    = (state_reg == MDU_BUSY);
  assign HILOOut = (HILOSel == HILO_SEL_HI) ? hilo_reg.hi : hilo_reg.lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: expected HI/LO/latency are queued at issue and
// popped when busy falls.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] srcA, srcB;
  logic [2:0]  MDUOp;
  logic        HILOSel;
  logic        busy;
  logic [31:0] HILOOut;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hi_m, lo_m;

  mdu dut (
    .clk(clk), .reset(reset), .srcA(srcA), .srcB(srcB),
    .MDUOp(MDUOp), .HILOSel(HILOSel), .busy(busy), .HILOOut(HILOOut)
  );

  always #5 clk = ~clk;

  // All helpers start and end just after a falling edge.
  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDUOp = op; srcA = a; srcB = b;
    @(negedge clk);
    MDUOp = MDU_NONE;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    HILOSel = 1'b1; #1 hi = HILOOut;
    HILOSel = 1'b0; #1 lo = HILOOut;
  endtask

  task automatic wait_done(input logic [31:0] old_lo, output int n, output bit held);
    n = 0; held = 1'b1; HILOSel = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      #1 if (HILOOut !== old_lo) held = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b1; MDUOp = MDU_NONE; srcA = '0; srcB = '0; HILOSel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    read_hilo(hi, lo);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    hi_m = '0; lo_m = '0;
    @(negedge clk);
  endtask

  task automatic run_sequence(input string name, input logic [2:0] ops[2], input logic [31:0] as[2],
                              input logic [31:0] bs[2], input exp_t ex[2]);
    int n; bit held; exp_t e; logic [31:0] hi, lo;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ex[i]);
      drive_op(ops[i], as[i], bs[i]);
      wait_done(lo_m, n, held);
      e = sb.pop_front();
      read_hilo(hi, lo);
      checks++; if (n !== e.cycles) begin errors++; $display("FAIL %s%0d_busy_cycles: got %0d expected %0d", name, i, n, e.cycles); end
      checks++; if (!held) begin errors++; $display("FAIL %s%0d_old_lo_while_busy: expected %h throughout", name, i, lo_m); end
      checks++; if (hi !== e.hi) begin errors++; $display("FAIL %s%0d_hi: got %h expected %h", name, i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin errors++; $display("FAIL %s%0d_lo: got %h expected %h", name, i, lo, e.lo); end
      $display("txn %s%0d op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", name, i, ops[i], as[i], bs[i], n, hi, lo);
      hi_m = e.hi; lo_m = e.lo;
    end
  endtask

  task automatic test_mult();
    run_sequence("mult", '{MDU_MULT, MDU_MULTU}, '{32'hFFFF_FFFD, 32'hFFFF_FFFF}, '{32'd5, 32'd2},
                 '{'{32'hFFFF_FFFF, 32'hFFFF_FFF1, 5}, '{32'h0000_0001, 32'hFFFF_FFFE, 5}});
  endtask

  task automatic test_div();
    run_sequence("div", '{MDU_DIV, MDU_DIVU}, '{32'hFFFF_FFF9, 32'hFFFF_FFF9}, '{32'd2, 32'd2},
                 '{'{32'hFFFF_FFFF, 32'hFFFF_FFFD, 10}, '{32'h0000_0001, 32'h7FFF_FFFC, 10}});
    run_sequence("divovf", '{MDU_DIV, MDU_DIV}, '{32'h8000_0000, 32'd7}, '{32'hFFFF_FFFF, 32'hFFFF_FFFE},
                 '{'{32'h0, 32'h8000_0000, 10}, '{32'h1, 32'hFFFF_FFFD, 10}});
  endtask

  task automatic test_div_zero();
    logic [31:0] hi, lo;
    drive_op(MDU_MTHI, 32'h11, 32'h0);
    HILOSel = 1'b1; #1;
    checks++; if (HILOOut !== 32'h11) begin errors++; $display("FAIL mthi_read: got %h expected 00000011", HILOOut); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
    @(negedge clk);
    drive_op(MDU_MTLO, 32'h22, 32'h0);
    HILOSel = 1'b0; #1;
    checks++; if (HILOOut !== 32'h22) begin errors++; $display("FAIL mtlo_read: got %h expected 00000022", HILOOut); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b expected 0", busy); end
    $display("txn preload hi=00000011 lo=00000022");
    @(negedge clk);
    hi_m = 32'h11; lo_m = 32'h22;
    run_sequence("divz", '{MDU_DIVU, MDU_DIV}, '{32'd7, 32'hFFFF_FFF0}, '{32'd0, 32'd0},
                 '{'{32'h11, 32'h22, 10}, '{32'h11, 32'h22, 10}});
  endtask

  task automatic test_ignore_busy();
    int n; logic [31:0] hi, lo;
    n = 0;
    drive_op(MDU_MULT, 32'd3, 32'd4);
    for (int c = 0; c < 9; c++) begin
      if (busy === 1'b1) n++;
      case (c)
        0:       begin MDUOp = MDU_MTLO; srcA = 32'hAAAA; end
        1, 2, 3: begin MDUOp = MDU_MULT; srcA = 32'd100; srcB = 32'd100; end
        default: MDUOp = MDU_NONE;
      endcase
      @(negedge clk);
    end
    read_hilo(hi, lo);
    checks++; if (n !== 5) begin errors++; $display("FAIL ignore_busy_cycles: got %0d expected 5", n); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ignore_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'hC) begin errors++; $display("FAIL ignore_lo: got %h expected 0000000c", lo); end
    $display("txn ignore_busy busy=%0d hi=%h lo=%h", n, hi, lo);
    hi_m = 32'h0; lo_m = 32'hC;
  endtask

  task automatic test_reset_mid();
    int late_busy; logic [31:0] hi, lo;
    drive_op(MDU_DIV, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk);  // now in busy cycle 3
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    read_hilo(hi, lo);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h expected 0", lo); end
    late_busy = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy !== 1'b0) late_busy++;
    end
    read_hilo(hi, lo);
    checks++; if (late_busy !== 0) begin errors++; $display("FAIL rstmid_late_busy: got %0d cycles expected 0", late_busy); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rstmid_late_write: got %h_%h expected 0_0", hi, lo); end
    $display("txn reset_mid hi=%h lo=%h", hi, lo);
    hi_m = '0; lo_m = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[3], b[3]; logic [63:0] pu; longint ps; int n; bit held; exp_t e; logic [31:0] hi, lo;
    logic [2:0] ops[3];
    ops = '{MDU_MULTU, MDU_DIVU, MDU_MULT};
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom; b[i] = $urandom;
      if (b[i] == 0) b[i] = 32'd9;
    end
    pu = {32'b0, a[0]} * {32'b0, b[0]};
    sb.push_back('{pu[63:32], pu[31:0], 5});
    sb.push_back('{a[1] % b[1], a[1] / b[1], 10});
    ps = longint'($signed(a[2])) * longint'($signed(b[2]));
    sb.push_back('{ps[63:32], ps[31:0], 5});
    for (int i = 0; i < 3; i++) begin
      drive_op(ops[i], a[i], b[i]);
      wait_done(lo_m, n, held);
      e = sb.pop_front();
      HILOSel = 1'b1; #1 hi = HILOOut;
      HILOSel = 1'b0; #1 lo = HILOOut;
      checks++; if (n !== e.cycles) begin errors++; $display("FAIL b2b%0d_busy_cycles: got %0d expected %0d", i, n, e.cycles); end
      checks++; if (hi !== e.hi) begin errors++; $display("FAIL b2b%0d_hi: got %h expected %h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin errors++; $display("FAIL b2b%0d_lo: got %h expected %h", i, lo, e.lo); end
      $display("txn b2b%0d op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", i, ops[i], a[i], b[i], n, hi, lo);
      hi_m = e.hi; lo_m = e.lo;
    end
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
Multiply/divide unit that sits in the EX stage beside the ALU. It consumes the forwarded operands regRD1 and regRD2 produced by the EX operand-forwarding muxes. It executes mult/multu/div/divu over multiple cycles and holds the architectural HI/LO registers. It also serves mthi/mtlo writes and mfhi/mflo reads, and exports busy so the hazard unit can stall MDU-dependent instructions in ID.

Parameters:
MULT_CYCLES, 5, cycles busy is held high after a mult/multu is issued
DIV_CYCLES, 10, cycles busy is held high after a div/divu is issued

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
srcA  input  32  operand rs (forwarded regRD1)
srcB  input  32  operand rt (forwarded regRD2)
MDUOp  input  3  operation for the instruction currently in EX: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
HILOSel  input  1  read select: 0 LO, 1 HI
busy  output  1  high while a multi-cycle operation is in flight
HILOOut  output  32  combinational read of the selected register, for mfhi/mflo

Behaviour:
- Reset (sync, active-high) has priority over everything and applies mid-operation too.
  - HI, LO, counter and latched results all go to 0.
  - State goes to IDLE and busy goes to 0.
  - An aborted operation never writes HI/LO.
- States: IDLE and BUSY, plus a down-counter (4 bits is sufficient for the defaults; size it from the max of the two parameters).
- Issue: MDUOp is MULT/MULTU/DIV/DIVU in IDLE during cycle T.
  - At the edge ending T, srcA and srcB are consumed and the 64-bit result is computed into internal regs.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES and the state moves to BUSY.
- Counting: busy = (state==BUSY).
  - busy is high in cycles T+1 .. T+N.
  - The counter decrements every cycle in BUSY.
  - At the edge where the counter goes 1→0: HI and LO are loaded from the result regs and the state returns to IDLE.
  - New HI/LO values are readable from cycle T+N+1, the first cycle busy is low.
- Arithmetic:
  - MULT: signed 32x32→64, HI = result[63:32], LO = result[31:0].
  - MULTU: unsigned 32x32→64, same split.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (srcB==0): the operation still occupies DIV_CYCLES, but HI and LO are left unchanged at completion.
- MTHI/MTLO in IDLE: HI (or LO) = srcA at that edge, visible next cycle; busy is not asserted.
- Any MDUOp while BUSY is ignored, whether mult/div or mthi/mtlo.
  - The hazard unit guarantees this does not happen by stalling on (busy || MDUOp issuing).
  - The block must still stay consistent and must not restart or corrupt HI/LO.
- NONE/reserved: no state change.
- Read path: HILOOut = HILOSel ? HI : LO, purely combinational.
  - During BUSY it returns the old, pre-operation HI/LO.
- Back-to-back: a new operation may issue in the first IDLE cycle after completion (T+N+1).

Decomposition:
- Shared constants file:
  - MDUOp encodings (MDU_NONE .. MDU_MTLO).
  - HILOSel encodings.
  - Default MULT_CYCLES/DIV_CYCLES values.
  - The controller decoding mult/div/mfhi/mflo/mthi/mtlo includes the same file.
- No sub-module: the arithmetic is behavioural (*, /, %) on 64/32-bit values with explicit $signed casts, and the FSM and counter live in this module.

Test Plan:
- MULT srcA=0xFFFFFFFD (-3), srcB=5 → busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFF1; HILOOut shows the old LO (0) while busy.
- MULTU srcA=0xFFFFFFFF, srcB=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV srcA=0xFFFFFFF9 (-7), srcB=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU 0xFFFFFFF9/2 → LO=0x7FFFFFFC, HI=1.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO (readable the next cycle, busy stays 0); DIVU 7/0 → busy 10 cycles, HI=0x11, LO=0x22 afterwards.
- MULT 3*4 issued, then MTLO 0xAAAA and a second MULT held on MDUOp during busy → both ignored; final HI=0, LO=0xC.
- DIV issued, reset asserted in busy cycle 3 → next cycle busy=0, HI=LO=0, and no write occurs at the original completion time.
